// File: rtl/pipe_pkg.sv
// Shared definitions for the core's inter-stage pipeline registers.
// Holds the occupancy/state encoding and the handshake helper.
package pipe_pkg;

  // Occupancy doubles as the state encoding: the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // A transfer happens when the offering side is valid and the taking side is ready.
  function automatic logic pipe_fire(input logic valid, input logic ready);
    return valid && ready;
  endfunction

endpackage : pipe_pkg

// File: rtl/pipe_stage.sv
// Parametrised inter-stage pipeline register with valid/ready handshake.
// Carries an opaque DATA_W payload. With SKID=1 a second entry gives a
// registered in_ready; with SKID=0 a single entry with combinational in_ready.
// flush inserts a bubble and counts discarded entries in a saturating counter.
import pipe_pkg::*;

module pipe_stage #(
  parameter int DATA_W         = 32,
  parameter int SKID           = 1,
  parameter int FLUSH_CLR_DATA = 1,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_drops
);

  // Adds a small increment to the discard counter, sticking at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W+1:0] sum;
    logic [CNT_W+1:0] lim;
    sum = {2'b00, cnt} + {{CNT_W{1'b0}}, inc};
    lim = {2'b00, {CNT_W{1'b1}}};
    if (sum > lim) return {CNT_W{1'b1}};
    return sum[CNT_W-1:0];
  endfunction

  pipe_state_t       state_q;
  pipe_state_t       state_d;
  logic              main_v;
  logic              skid_v;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_d;
  logic              in_fire;
  logic              out_fire;
  logic              ld_main_in;
  logic              ld_main_skid;
  logic              ld_skid_in;
  logic              clr_data;
  logic [1:0]        held;
  logic [1:0]        drop_inc;

  // Valid bits are decoded straight from the state flops, so in_ready in
  // skid mode has no combinational path from out_ready.
  assign main_v    = (state_q != EMPTY);
  assign skid_v    = (state_q == FULL);
  assign held      = {1'b0, main_v} + {1'b0, skid_v};

  assign in_ready  = (SKID != 0) ? !skid_v : (!main_v || out_ready);
  assign in_fire   = pipe_fire(in_valid, in_ready);
  assign out_fire  = pipe_fire(main_v, out_ready);

  assign out_valid = main_v;
  assign out_data  = main_d;
  assign occupancy = state_q;

  // State register; reset wins over flush.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next state and datapath load strobes; flush overrides normal transfers.
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid_in   = 1'b0;
    clr_data     = 1'b0;
    drop_inc     = 2'd0;
    if (flush) begin
      state_d  = EMPTY;
      clr_data = (FLUSH_CLR_DATA != 0);
      // Entries delivered by out_fire this cycle are not drops; an entry
      // accepted this cycle is taken and then thrown away.
      drop_inc = held - {1'b0, out_fire} + {1'b0, in_fire};
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d    = ONE;
            ld_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            ld_main_in = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end else if (in_fire && (SKID != 0)) begin
            state_d    = FULL;
            ld_skid_in = 1'b1;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain direction can fire.
          if (out_fire) begin
            state_d      = ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // ---- main entry: drives the outputs ----
  // Main payload register: loads from upstream or promotes the skid entry.
  always_ff @(posedge clk) begin
    if (rst)               main_d <= '0;
    else if (clr_data)     main_d <= '0;
    else if (ld_main_in)   main_d <= in_data;
    else if (ld_main_skid) main_d <= skid_d;
  end

  // ---- skid entry: absorbs one beat while the downstream stalls ----
  generate
    if (SKID != 0) begin : g_skid
      // Skid payload register, written only on the ONE -> FULL transition.
      always_ff @(posedge clk) begin
        if (rst)             skid_d <= '0;
        else if (clr_data)   skid_d <= '0;
        else if (ld_skid_in) skid_d <= in_data;
      end
    end else begin : g_no_skid
      logic unused_skid_ld;
      assign unused_skid_ld = ld_skid_in;
      assign skid_d         = '0;
    end
  endgenerate

  // Saturating count of entries discarded by flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)        flush_drops <= '0;
    else if (flush) flush_drops <= sat_add(flush_drops, drop_inc);
  end

endmodule : pipe_stage

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: skid streaming, backpressure, flush
// accounting, single-entry mode and counter saturation.
module tb_pipe_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: SKID=1, clear-on-flush, 8-bit counter.
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;
  logic [7:0]  a_drops;

  // Instance B: SKID=0.
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;
  logic [7:0]  b_drops;

  // Instance C: SKID=1, 2-bit counter for saturation.
  logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [31:0] c_in_data, c_out_data;
  logic [1:0]  c_occ;
  logic [1:0]  c_drops;

  pipe_stage #(.DATA_W(32), .SKID(1), .FLUSH_CLR_DATA(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .flush_drops(a_drops));

  pipe_stage #(.DATA_W(32), .SKID(0), .FLUSH_CLR_DATA(1), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .flush_drops(b_drops));

  pipe_stage #(.DATA_W(32), .SKID(1), .FLUSH_CLR_DATA(1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .occupancy(c_occ), .flush_drops(c_drops));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    c_flush = 0; c_in_valid = 0; c_in_data = 0; c_out_ready = 0;
    tick();
    rst = 1'b0;

    // Reset values
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data",  a_out_data, 0);
    chk("rst_occ",       a_occ, 0);
    chk("rst_drops",     a_drops, 0);
    chk("rst_in_ready",  a_in_ready, 1);
    chk("rst_in_ready_noskid", b_in_ready, 1);

    // Streaming: each beat visible one edge after acceptance, no gaps
    a_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1; a_in_data = i;
      tick();
      chk($sformatf("stream_valid_%0d", i), a_out_valid, 1);
      chk($sformatf("stream_data_%0d", i), a_out_data, i);
      chk($sformatf("stream_occ_%0d", i), a_occ, 1);
    end
    a_in_valid = 0;
    tick();
    chk("stream_drain", a_out_valid, 0);

    // Backpressure: A, B, C with downstream stalled
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'hA;
    tick();
    chk("bp_occ1", a_occ, 1);
    chk("bp_dataA", a_out_data, 32'hA);
    a_in_data = 32'hB;
    tick();
    chk("bp_occ2", a_occ, 2);
    chk("bp_in_ready_full", a_in_ready, 0);
    chk("bp_hold_A", a_out_data, 32'hA);
    a_in_data = 32'hC;
    tick();
    chk("bp_still_full", a_occ, 2);
    chk("bp_still_A", a_out_data, 32'hA);
    a_out_ready = 1;
    tick();
    chk("bp_rel_B", a_out_data, 32'hB);
    chk("bp_rel_occ", a_occ, 1);
    tick();
    chk("bp_rel_C", a_out_data, 32'hC);
    chk("bp_rel_C_valid", a_out_valid, 1);
    a_in_valid = 0;
    tick();
    chk("bp_empty", a_out_valid, 0);

    // Flush in FULL, downstream stalled: both entries dropped
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'hD;
    tick();
    a_in_data = 32'hE;
    tick();
    a_in_valid = 0;
    chk("fl1_pre_occ", a_occ, 2);
    a_flush = 1;
    tick();
    a_flush = 0;
    chk("fl1_out_valid", a_out_valid, 0);
    chk("fl1_occ", a_occ, 0);
    chk("fl1_data_clr", a_out_data, 0);
    chk("fl1_drops", a_drops, 2);

    // Flush in FULL, downstream ready: main entry delivered, one drop (total 3)
    a_in_valid = 1; a_in_data = 32'hF;
    tick();
    a_in_data = 32'h10;
    tick();
    a_in_valid = 0;
    chk("fl2_pre_occ", a_occ, 2);
    a_out_ready = 1; a_flush = 1;
    tick();
    a_flush = 0;
    chk("fl2_drops", a_drops, 3);
    chk("fl2_occ", a_occ, 0);

    // Flush with in_fire from EMPTY: accepted then discarded (total 4)
    a_in_valid = 1; a_in_data = 32'h55; a_flush = 1;
    tick();
    a_flush = 0; a_in_valid = 0;
    chk("fl3_drops", a_drops, 4);
    chk("fl3_out_valid", a_out_valid, 0);

    // Single-entry mode: in_ready follows out_ready combinationally
    b_out_ready = 0;
    b_in_valid = 1; b_in_data = 32'h11;
    tick();
    chk("ns_occ1", b_occ, 1);
    chk("ns_in_ready_stall", b_in_ready, 0);
    b_in_data = 32'h22;
    tick();
    chk("ns_occ_max1", b_occ, 1);
    chk("ns_hold", b_out_data, 32'h11);
    b_out_ready = 1;
    #1;
    chk("ns_in_ready_comb", b_in_ready, 1);
    tick();
    chk("ns_pass", b_out_data, 32'h22);
    chk("ns_occ_pass", b_occ, 1);
    b_in_valid = 0;
    tick();
    chk("ns_empty", b_out_valid, 0);

    // Saturation: five single-entry drop flushes on a 2-bit counter
    for (int i = 1; i <= 5; i++) begin
      c_in_valid = 1; c_in_data = i; c_flush = 1;
      tick();
      if (i == 3) chk("sat_at3", c_drops, 3);
    end
    c_flush = 0; c_in_valid = 0;
    chk("sat_final", c_drops, 3);
    chk("sat_out_valid", c_out_valid, 0);

    // Reset while FULL clears everything in one cycle
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h77;
    tick();
    a_in_data = 32'h88;
    tick();
    a_in_valid = 0;
    chk("rf_pre_occ", a_occ, 2);
    rst = 1;
    tick();
    rst = 0;
    chk("rf_out_valid", a_out_valid, 0);
    chk("rf_out_data", a_out_data, 0);
    chk("rf_occ", a_occ, 0);
    chk("rf_drops", a_drops, 0);
    chk("rf_in_ready", a_in_ready, 1);
    chk("rf_sat_cleared", c_drops, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Bound the run in case something stalls the sequence.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_pipe_stage
